// File: rtl/nibble_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_sched
// Purpose  : Shares one external 4-bit adder between two requesters, adding
//            WIDTH-bit operands one nibble per clock with a registered carry.
//            Define NIBBLE_ADD_OVF_EN to add the signed-overflow output rsp_ovf.
// Revision : 1.0
// ============================================================================
module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_ci,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_ci,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_s,
    input  logic             add_co,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
`ifdef NIBBLE_ADD_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             last_grant_q, last_grant_d;
`ifdef NIBBLE_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             w_grant0, w_grant1;
    logic [IDXW+1:0]  w_base;

    // Round-robin on ties: the requester not served last time wins.
    assign w_grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign w_grant1 = req1_valid && (!req0_valid || !last_grant_q);
    assign w_base   = {idx_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef NIBBLE_ADD_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            last_grant_q <= last_grant_d;
`ifdef NIBBLE_ADD_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        last_grant_d = last_grant_q;
`ifdef NIBBLE_ADD_OVF_EN
        ovf_d        = ovf_q;
`endif
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        add_a        = 4'h0;
        add_b        = 4'h0;
        add_ci       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    a_d          = w_grant1 ? req1_a  : req0_a;
                    b_d          = w_grant1 ? req1_b  : req0_b;
                    carry_d      = w_grant1 ? req1_ci : req0_ci;
                    rsp_id_d     = w_grant1;
                    last_grant_d = w_grant1;
                    idx_d        = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a                 = a_q[w_base +: 4];
                add_b                 = b_q[w_base +: 4];
                add_ci                = carry_q;
                rsp_sum_d[w_base +: 4] = add_s;
                carry_d               = add_co;
                idx_d                 = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    rsp_cout_d  = add_co;
                    rsp_valid_d = 1'b1;
`ifdef NIBBLE_ADD_OVF_EN
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
`endif
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
`ifdef NIBBLE_ADD_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_add_sched
// Purpose  : Directed self-checking bench for nibble_add_sched (WIDTH=16),
//            modelling the external 4-bit adder. Covers NIBBLE_ADD_OVF_EN too.
// Revision : 1.0
// ============================================================================
module tb_nibble_add_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_ci;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_ci;
    logic [15:0] req1_a, req1_b;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_ci, add_co;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [15:0] rsp_sum;
`ifdef NIBBLE_ADD_OVF_EN
    logic        rsp_ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural model of the external combinational nibble adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_ci};

    nibble_add_sched #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef NIBBLE_ADD_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until rsp_valid is seen (bounded); returns edges waited.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_rsp: got v=%b id=%b co=%b sum=%h, want all 0",
                     rsp_valid, rsp_id, rsp_cout, rsp_sum);
        end
        n_vec++;
        if ({add_a, add_b, add_ci, req0_ready, req1_ready} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_idle: got add_a=%h add_b=%h ci=%b rdy=%b%b, want 0",
                     add_a, add_b, add_ci, req0_ready, req1_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_ci = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req0_a = 16'h5A5A;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ready_pulse: got %b want 0", req0_ready);
        end
        wait_rsp(lat);
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges want 4", lat);
        end
        n_vec++;
        if ({rsp_cout, rsp_sum, rsp_id} !== {1'b1, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: got co=%b sum=%h id=%b want co=1 sum=0000 id=0",
                     rsp_cout, rsp_sum, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_take: rsp_valid got %b want 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_req1_carry();
        int lat;
        logic [3:0] exp_ci;
        exp_ci = 4'b0001;
        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h4321; req1_ci = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL req1_ready: got %b%b want 01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0; req1_ci = 1'b0; req1_a = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (add_ci !== exp_ci[k]) begin
                n_err++;
                $display("FAIL req1_add_ci[%0d]: got %b want %b", k, add_ci, exp_ci[k]);
            end
        end
        tick();
        wait_rsp(lat);
        n_vec++;
        if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {1'b1, 1'b0, 16'h5556, 1'b1}) begin
            n_err++;
            $display("FAIL req1_result: got v=%b co=%b sum=%h id=%b want v=1 co=0 sum=5556 id=1",
                     rsp_valid, rsp_cout, rsp_sum, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [2][2];
        logic [15:0] tb [2][2];
        logic        tc [2][2];
        logic [16:0] tr [2][2];
        int          opn [2];
        int          cnt, lat, gid;
        ta[0][0] = 16'h0F0F; tb[0][0] = 16'h00F1; tc[0][0] = 1'b0; tr[0][0] = 17'h01000;
        ta[0][1] = 16'hAAAA; tb[0][1] = 16'h5555; tc[0][1] = 1'b1; tr[0][1] = 17'h10000;
        ta[1][0] = 16'h8000; tb[1][0] = 16'h8000; tc[1][0] = 1'b0; tr[1][0] = 17'h10000;
        ta[1][1] = 16'h1111; tb[1][1] = 16'h2222; tc[1][1] = 1'b1; tr[1][1] = 17'h03334;
        opn[0] = 0; opn[1] = 0;
        req0_a = ta[0][0]; req0_b = tb[0][0]; req0_ci = tc[0][0];
        req1_a = ta[1][0]; req1_b = tb[1][0]; req1_ci = tc[1][0];
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            cnt = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && cnt < 12) begin
                @(negedge clk);
                cnt++;
            end
            gid = req1_ready ? 1 : 0;
            n_vec++;
            if (!(req0_ready || req1_ready) || gid != (g % 2)) begin
                n_err++;
                $display("FAIL b2b_grant[%0d]: got rdy=%b%b want grant %0d",
                         g, req0_ready, req1_ready, g % 2);
            end
            tick();
            if (opn[gid] < 1) begin
                if (gid == 0) begin
                    req0_a = ta[0][1]; req0_b = tb[0][1]; req0_ci = tc[0][1];
                end else begin
                    req1_a = ta[1][1]; req1_b = tb[1][1]; req1_ci = tc[1][1];
                end
            end
            if (g == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            wait_rsp(lat);
            n_vec++;
            if (!rsp_valid || rsp_id !== gid[0] || {rsp_cout, rsp_sum} !== tr[gid][opn[gid]]) begin
                n_err++;
                $display("FAIL b2b_result[%0d]: got v=%b id=%b co/sum=%h want id=%0d co/sum=%h",
                         g, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, gid, tr[gid][opn[gid]]);
            end
            opn[gid]++;
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_ci = 1'b0;
        req1_a = 16'h0003; req1_b = 16'h0004; req1_ci = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: req0_ready got %b want 1", req0_ready);
        end
        tick();
        req0_a = 16'hDEAD; req1_valid = 1'b1;
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready} !==
                {1'b1, 1'b0, 1'b0, 16'h0100, 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%b co=%b sum=%h rdy=%b%b want v=1 id=0 co=0 sum=0100 rdy=00",
                         k, rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; req0_valid = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_take: rsp_valid got %b want 0", rsp_valid);
        end
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_idle_next: got rdy=%b%b want 01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        wait_rsp(lat);
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b1, 1'b0, 16'h0007}) begin
            n_err++;
            $display("FAIL bp_next_result: got v=%b id=%b co=%b sum=%h want v=1 id=1 co=0 sum=0007",
                     rsp_valid, rsp_id, rsp_cout, rsp_sum);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int  lat;
        logic seen;
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF; req0_ci = 1'b1;
        @(negedge clk);
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_sum, add_a, add_ci} !== 24'h0) begin
            n_err++;
            $display("FAIL abort_reset: got v=%b id=%b co=%b sum=%h add_a=%h ci=%b want all 0",
                     rsp_valid, rsp_id, rsp_cout, rsp_sum, add_a, add_ci);
        end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | rsp_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_rsp: rsp_valid seen=%b want 0", seen);
        end
        req0_valid = 1'b1; req0_a = 16'h0042; req0_b = 16'h0018; req0_ci = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_ci = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_grant: got rdy=%b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat);
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b0, 1'b0, 16'h005A}) begin
            n_err++;
            $display("FAIL abort_fresh: got v=%b id=%b co=%b sum=%h want v=1 id=0 co=0 sum=005a",
                     rsp_valid, rsp_id, rsp_cout, rsp_sum);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

`ifdef NIBBLE_ADD_OVF_EN
    task automatic test_ovf();
        int lat;
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [17:0] vr [2];
        va[0] = 16'h7FFF; vb[0] = 16'h0001; vr[0] = {1'b1, 1'b0, 16'h8000};
        va[1] = 16'h8000; vb[1] = 16'hFFFF; vr[1] = {1'b1, 1'b1, 16'h7FFF};
        for (int k = 0; k < 2; k++) begin
            req0_valid = 1'b1; req0_a = va[k]; req0_b = vb[k]; req0_ci = 1'b0;
            @(negedge clk);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_rsp(lat);
            n_vec++;
            if (!rsp_valid || {rsp_ovf, rsp_cout, rsp_sum} !== vr[k]) begin
                n_err++;
                $display("FAIL ovf[%0d]: got v=%b ovf/co/sum=%h want %h",
                         k, rsp_valid, {rsp_ovf, rsp_cout, rsp_sum}, vr[k]);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_req1_carry();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
`ifdef NIBBLE_ADD_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
